uart_word_loader: RTL and testbench
===================================

# uart_word_loader

UART-fed program loader that sits directly upstream of the LnL SoC core's program memory. It deserialises 8N1 bytes from the `ui_in[0]` pad and assembles framed, checksummed 16-bit write commands. Each accepted frame produces a single-cycle memory write strobe. It also holds the core in reset while a frame is in flight.

## Interface
- `CLKS_PER_BIT`, 16: clock cycles per UART bit. Legal range 4..4095.
- `TIMEOUT_BITS`, 20: maximum idle gap between bytes inside a frame, in bit times.
- `SYNC_BYTE`, 8'hA5: frame start marker.

Ports (clock and reset first):
- `clk` input 1: sole clock.
- `rst_n` input 1: reset, asynchronous and active-low.
- `rx` input 1: raw UART line; asynchronous to `clk`; idle high.
- `mem_we` output 1: one-cycle write strobe.
- `mem_addr` output 8: word address; valid while `mem_we` is high.
- `mem_wdata` output 16: write data; valid while `mem_we` is high.
- `err` output 1: one-cycle pulse on framing, checksum or timeout error.
- `busy` output 1: high from acceptance of the sync byte until the frame completes or aborts; the core's reset is gated by this signal.

## Operation
- Reset values:
  - outputs `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `err`=0, `busy`=0.
  - synchroniser flops = 1.
  - receiver in IDLE; frame FSM in HUNT.
- Input path: two-flop synchroniser on `rx`. All logic uses the synchronised value.
- Byte receiver FSM:
  - IDLE: a falling edge (prev 1, now 0) moves to START; bit counter = CLKS_PER_BIT/2 − 1 (integer division).
  - START: at counter expiry, resample. If 0, go to DATA with counter reload CLKS_PER_BIT − 1. If 1 (glitch), go back to IDLE with no error.
  - DATA: sample 8 bits, LSB first, one per CLKS_PER_BIT cycles at bit centre, then go to STOP.
  - STOP: sample at bit centre. If 1, raise `byte_valid` for one cycle. If 0, raise `frame_err` for one cycle. Either way, return to IDLE immediately; do not wait out the stop bit.
- Frame FSM, advanced only by `byte_valid`:
  - HUNT: a byte equal to SYNC_BYTE goes to ADDR and sets `busy`. Other bytes are discarded silently.
  - ADDR: latch the address and set `chk` = byte, then go to LO.
  - LO: latch `wdata[7:0]`, `chk ^= byte`, then go to HI.
  - HI: latch `wdata[15:8]`, `chk ^= byte`, then go to CHK.
  - CHK:
    - byte == chk: pulse `mem_we`.
    - otherwise: pulse `err`.
    - both cases: go to HUNT and clear `busy`.
- Abort conditions while not in HUNT. Each one pulses `err`, returns to HUNT and clears `busy`; no `mem_we` is issued:
  - `frame_err`;
  - idle-gap counter reaching CLKS_PER_BIT*TIMEOUT_BITS cycles. The counter is cleared on every `byte_valid` and counts only while the receiver is in IDLE.
- `frame_err` while in HUNT: no `err` pulse and no state change.
- `mem_addr` and `mem_wdata` are registered and change only in the cycle `mem_we` is asserted; they hold their value afterwards.
- A SYNC_BYTE value received in ADDR, LO, HI or CHK is treated as data, not as a resync.

## Timing
- Synchroniser latency: 2 cycles.
- The stop-bit sample falls ≈ 9.5 bit times + 2 cycles after the start-bit falling edge on `rx`.
- `byte_valid` is registered in the cycle after the stop sample.
- For the checksum byte, `mem_we`/`err` assert in the cycle after its `byte_valid`, and `busy` drops in that same cycle.
- `busy` rises in the cycle after the sync byte's `byte_valid`.
- Timeout abort: `err` asserts in the cycle after the counter reaches its limit.
- Back-to-back bytes are accepted with zero idle cycles after the stop sample; the next falling edge may occur in any later cycle.
- Reset asserted mid-frame:
  - all state and outputs return to reset values immediately (asynchronous);
  - no strobe is issued;
  - after release, the receiver waits for a fresh falling edge.
- `mem_we` and `err` are never high in the same cycle and are never high for two consecutive cycles.

## Test plan
(All scenarios use CLKS_PER_BIT=8 and TIMEOUT_BITS=20.)
- Good frame: send A5 12 34 56 70 → exactly one `mem_we` pulse with `mem_addr`=0x12, `mem_wdata`=0x5634. `busy` is high from after A5 until that pulse. `err` never fires.
- Bad checksum: send A5 12 34 56 71 → one `err` pulse, no `mem_we`, `busy` low afterwards. A following good frame A5 01 FF 00 FE writes addr 0x01, data 0x00FF.
- Framing error: send A5 12 then a byte with stop bit 0 → `err` pulse and `busy` low. Garbage bytes 00 3C in HUNT produce no `err` and no `mem_we`.
- Timeout: send A5 12 then hold `rx` high for 160 cycles → `err` in the cycle after the 160th idle cycle. The counter is cleared by `byte_valid`.
- Glitch and back-to-back: a 2-cycle low pulse on `rx` produces no byte. Two good frames sent with zero extra idle produce two `mem_we` pulses with the correct addresses.
- Reset mid-frame: assert `rst_n`=0 during the LO byte → all outputs 0 at once. After release, a full good frame writes correctly.

Source files
------------

// File: rtl/uart_word_loader.sv
// UART (8N1) program loader: assembles SYNC/ADDR/LO/HI/CHK frames into single-cycle
// 16-bit memory writes and holds the core in reset (busy) while a frame is in flight.
module uart_word_loader #(
  parameter int         CLKS_PER_BIT = 16,
  parameter int         TIMEOUT_BITS = 20,
  parameter logic [7:0] SYNC_BYTE    = 8'hA5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx,
  output logic        mem_we,
  output logic [7:0]  mem_addr,
  output logic [15:0] mem_wdata,
  output logic        err,
  output logic        busy
);

  localparam logic [11:0]      HALF_RELOAD = 12'(CLKS_PER_BIT / 2 - 1);
  localparam logic [11:0]      FULL_RELOAD = 12'(CLKS_PER_BIT - 1);
  localparam int               GAP_LIMIT   = CLKS_PER_BIT * TIMEOUT_BITS;
  localparam int               GAP_W       = $clog2(GAP_LIMIT + 1);
  localparam logic [GAP_W-1:0] GAP_LAST    = GAP_W'(GAP_LIMIT - 1);
  localparam logic [GAP_W-1:0] GAP_ONE     = {{(GAP_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_e;

  typedef enum logic [2:0] {
    F_HUNT = 3'd0,
    F_ADDR = 3'd1,
    F_LO   = 3'd2,
    F_HI   = 3'd3,
    F_CHK  = 3'd4
  } frame_state_e;

  logic             rx_meta_r, rx_sync_r, rx_prev_r;
  rx_state_e        rx_state_r, rx_next_s;
  logic [11:0]      cnt_r;
  logic [2:0]       bit_idx_r;
  logic [7:0]       shift_r;
  logic             byte_valid_r, frame_err_r;
  logic             bit_tick_s;
  frame_state_e     f_state_r, f_next_s;
  logic [7:0]       addr_r, lo_r, hi_r, chk_r;
  logic [GAP_W-1:0] gap_r;
  logic             gap_count_s, timeout_s, abort_s, we_s, err_s;

  assign bit_tick_s  = (cnt_r == 12'd0);
  assign gap_count_s = (rx_state_r == RX_IDLE) && (f_state_r != F_HUNT) && !byte_valid_r;
  assign timeout_s   = gap_count_s && (gap_r == GAP_LAST);
  assign abort_s     = (f_state_r != F_HUNT) && (frame_err_r || timeout_s);

  // Two-flop synchroniser plus previous-value flop for falling-edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_r <= 1'b1;
      rx_sync_r <= 1'b1;
      rx_prev_r <= 1'b1;
    end else begin
      rx_meta_r <= rx;
      rx_sync_r <= rx_meta_r;
      rx_prev_r <= rx_sync_r;
    end
  end

  // Receiver state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state_r <= RX_IDLE;
    end else begin
      rx_state_r <= rx_next_s;
    end
  end

  // Receiver next-state logic
  always_comb begin
    rx_next_s = rx_state_r;
    case (rx_state_r)
      RX_IDLE: begin
        if (rx_prev_r && !rx_sync_r) rx_next_s = RX_START;
        else                         rx_next_s = RX_IDLE;
      end
      RX_START: begin
        if (bit_tick_s) rx_next_s = rx_sync_r ? RX_IDLE : RX_DATA;
        else            rx_next_s = RX_START;
      end
      RX_DATA: begin
        if (bit_tick_s && (bit_idx_r == 3'd7)) rx_next_s = RX_STOP;
        else                                   rx_next_s = RX_DATA;
      end
      RX_STOP: begin
        if (bit_tick_s) rx_next_s = RX_IDLE;
        else            rx_next_s = RX_STOP;
      end
      default: rx_next_s = RX_IDLE;
    endcase
  end

  // Receiver datapath: bit timer, LSB-first shifter and the byte/framing-error pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r        <= 12'd0;
      bit_idx_r    <= 3'd0;
      shift_r      <= 8'd0;
      byte_valid_r <= 1'b0;
      frame_err_r  <= 1'b0;
    end else begin
      byte_valid_r <= 1'b0;
      frame_err_r  <= 1'b0;
      case (rx_state_r)
        RX_IDLE: begin
          cnt_r     <= HALF_RELOAD;
          bit_idx_r <= 3'd0;
        end
        RX_START: begin
          cnt_r <= bit_tick_s ? FULL_RELOAD : cnt_r - 12'd1;
        end
        RX_DATA: begin
          if (bit_tick_s) begin
            cnt_r     <= FULL_RELOAD;
            shift_r   <= {rx_sync_r, shift_r[7:1]};
            bit_idx_r <= bit_idx_r + 3'd1;
          end else begin
            cnt_r <= cnt_r - 12'd1;
          end
        end
        RX_STOP: begin
          if (bit_tick_s) begin
            byte_valid_r <= rx_sync_r;
            frame_err_r  <= !rx_sync_r;
          end else begin
            cnt_r <= cnt_r - 12'd1;
          end
        end
        default: cnt_r <= HALF_RELOAD;
      endcase
    end
  end

  // Inter-byte idle-gap counter; only advances while the line is idle inside a frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gap_r <= '0;
    end else if (byte_valid_r) begin
      gap_r <= '0;
    end else if (gap_count_s) begin
      gap_r <= gap_r + GAP_ONE;
    end else begin
      gap_r <= gap_r;
    end
  end

  // Frame state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f_state_r <= F_HUNT;
    end else begin
      f_state_r <= f_next_s;
    end
  end

  // Frame next-state logic with write/error decisions
  always_comb begin
    f_next_s = f_state_r;
    we_s     = 1'b0;
    err_s    = 1'b0;
    if (abort_s) begin
      f_next_s = F_HUNT;
      err_s    = 1'b1;
    end else if (byte_valid_r) begin
      case (f_state_r)
        F_HUNT: begin
          if (shift_r == SYNC_BYTE) f_next_s = F_ADDR;
          else                      f_next_s = F_HUNT;
        end
        F_ADDR: f_next_s = F_LO;
        F_LO:   f_next_s = F_HI;
        F_HI:   f_next_s = F_CHK;
        F_CHK: begin
          f_next_s = F_HUNT;
          if (shift_r == chk_r) we_s  = 1'b1;
          else                  err_s = 1'b1;
        end
        default: f_next_s = F_HUNT;
      endcase
    end else begin
      f_next_s = f_state_r;
    end
  end

  // Frame datapath and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_r    <= 8'd0;
      lo_r      <= 8'd0;
      hi_r      <= 8'd0;
      chk_r     <= 8'd0;
      mem_we    <= 1'b0;
      mem_addr  <= 8'd0;
      mem_wdata <= 16'd0;
      err       <= 1'b0;
      busy      <= 1'b0;
    end else begin
      mem_we <= we_s;
      err    <= err_s;
      busy   <= (f_next_s != F_HUNT);
      if (we_s) begin
        mem_addr  <= addr_r;
        mem_wdata <= {hi_r, lo_r};
      end
      if (byte_valid_r && !abort_s) begin
        case (f_state_r)
          F_ADDR: begin
            addr_r <= shift_r;
            chk_r  <= shift_r;
          end
          F_LO: begin
            lo_r  <= shift_r;
            chk_r <= chk_r ^ shift_r;
          end
          F_HI: begin
            hi_r  <= shift_r;
            chk_r <= chk_r ^ shift_r;
          end
          default: chk_r <= chk_r;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_word_loader.sv
// Self-checking bench for uart_word_loader: frame-level reference model fed from the
// UART stimulus, compared against the DUT every cycle, plus hand-computed pin checks.
module tb_uart_word_loader;

  localparam int         CPB  = 8;
  localparam int         TOB  = 20;
  localparam logic [7:0] SYNC = 8'hA5;
  // Cycles from the start-bit drive until the frame outputs react to that byte
  localparam int LAT   = 4 + CPB / 2 + 9 * CPB;
  localparam int TOGAP = CPB * TOB;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx = 1'b1;
  logic        mem_we, err, busy;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata;

  uart_word_loader #(.CLKS_PER_BIT(CPB), .TIMEOUT_BITS(TOB), .SYNC_BYTE(SYNC)) dut (
    .clk(clk), .rst_n(rst_n), .rx(rx), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .err(err), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          t;
    int          kind;   // 0 busy on, 1 write, 2 error
    logic [7:0]  a;
    logic [15:0] d;
  } ev_t;

  ev_t        evq[$];
  logic [7:0] fbuf[$];
  int         deadline = 0;
  logic       exp_busy = 1'b0;
  logic [7:0] exp_addr = 8'h00;
  logic [15:0] exp_data = 16'h0000;

  int checks = 0, failures = 0;
  int we_cnt = 0, err_cnt = 0, err_cyc = -1;
  logic [7:0]  last_addr = 8'h00;
  logic [15:0] last_data = 16'h0000;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void push_ev(input int t, input int kind, input logic [7:0] a, input logic [15:0] d);
    ev_t ev;
    ev.t = t; ev.kind = kind; ev.a = a; ev.d = d;
    evq.push_back(ev);
  endfunction

  // Frame-level model: a byte whose start bit is driven at cycle e takes effect at e+LAT
  function automatic void model_byte(input int e, input logic [7:0] b, input bit stop_ok);
    int t;
    t = e + LAT;
    if (!stop_ok) begin
      if (fbuf.size() > 0) begin
        push_ev(t, 2, 8'h00, 16'h0000);
        fbuf.delete();
      end
    end else if (fbuf.size() == 0) begin
      if (b == SYNC) begin
        fbuf.push_back(b);
        push_ev(t, 0, 8'h00, 16'h0000);
        deadline = t + TOGAP;
      end
    end else begin
      fbuf.push_back(b);
      if (fbuf.size() == 5) begin
        if ((fbuf[1] ^ fbuf[2] ^ fbuf[3]) == fbuf[4]) push_ev(t, 1, fbuf[1], {fbuf[3], fbuf[2]});
        else                                          push_ev(t, 2, 8'h00, 16'h0000);
        fbuf.delete();
      end else begin
        deadline = t + TOGAP;
      end
    end
  endfunction

  // Per-cycle comparison against the model, plus pulse bookkeeping for pin checks
  always @(negedge clk) begin : cmp
    logic e_we, e_err;
    ev_t  ev;
    if (rst_n) begin
      e_we = 1'b0;
      e_err = 1'b0;
      while (evq.size() > 0 && evq[0].t <= cyc) begin
        ev = evq.pop_front();
        if (ev.kind == 0) exp_busy = 1'b1;
        else if (ev.kind == 1) begin
          e_we = 1'b1; exp_busy = 1'b0; exp_addr = ev.a; exp_data = ev.d;
        end else begin
          e_err = 1'b1; exp_busy = 1'b0;
        end
      end
      if (fbuf.size() > 0 && cyc == deadline) begin
        e_err = 1'b1; exp_busy = 1'b0;
        fbuf.delete();
      end
      check("mem_we", {31'd0, mem_we}, {31'd0, e_we});
      check("err", {31'd0, err}, {31'd0, e_err});
      check("busy", {31'd0, busy}, {31'd0, exp_busy});
      check("mem_addr", {24'd0, mem_addr}, {24'd0, exp_addr});
      check("mem_wdata", {16'd0, mem_wdata}, {16'd0, exp_data});
      if (mem_we) begin
        we_cnt++; last_addr = mem_addr; last_data = mem_wdata;
      end
      if (err) begin
        err_cnt++; err_cyc = cyc;
      end
    end
  end

  // All driver tasks start and end 1 time unit after a rising edge
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stop_ok);
    model_byte(cyc, b, stop_ok);
    rx = 1'b0;
    step(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      step(CPB);
    end
    rx = stop_ok;
    step(CPB);
    rx = 1'b1;
    if (!stop_ok) step(4);
  endtask

  task automatic send_frame(input logic [7:0] a, input logic [7:0] lo, input logic [7:0] hi,
                            input logic [7:0] ck, input int gap);
    logic [7:0] fb[5];
    fb[0] = SYNC; fb[1] = a; fb[2] = lo; fb[3] = hi; fb[4] = ck;
    for (int i = 0; i < 5; i++) begin
      send_byte(fb[i], 1'b1);
      if (gap > 0) step(gap);
    end
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin : stim
    int w0, e0, e12, ng, mode, p;
    logic [7:0] fb[5];
    logic [7:0] b;

    rx = 1'b1;
    rst_n = 1'b0;
    step(3);
    check("reset_we", {31'd0, mem_we}, 32'd0);
    check("reset_err", {31'd0, err}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_addr", {24'd0, mem_addr}, 32'd0);
    check("reset_wdata", {16'd0, mem_wdata}, 32'd0);
    rst_n = 1'b1;
    step(5);

    // Good frame
    w0 = we_cnt; e0 = err_cnt;
    send_byte(8'hA5, 1'b1);
    check("busy_after_sync", {31'd0, busy}, 32'd1);
    send_byte(8'h12, 1'b1);
    send_byte(8'h34, 1'b1);
    send_byte(8'h56, 1'b1);
    send_byte(8'h70, 1'b1);
    step(5);
    check("good_we_count", we_cnt - w0, 32'd1);
    check("good_addr", {24'd0, last_addr}, 32'h12);
    check("good_data", {16'd0, last_data}, 32'h5634);
    check("good_no_err", err_cnt - e0, 32'd0);

    // Bad checksum followed by a good frame
    w0 = we_cnt; e0 = err_cnt;
    send_frame(8'h12, 8'h34, 8'h56, 8'h71, 0);
    step(5);
    check("badchk_err", err_cnt - e0, 32'd1);
    check("badchk_no_we", we_cnt - w0, 32'd0);
    check("badchk_busy", {31'd0, busy}, 32'd0);
    send_frame(8'h01, 8'hFF, 8'h00, 8'hFE, 3);
    step(5);
    check("after_bad_we", we_cnt - w0, 32'd1);
    check("after_bad_addr", {24'd0, last_addr}, 32'h01);
    check("after_bad_data", {16'd0, last_data}, 32'h00FF);

    // Framing error mid-frame, then garbage in HUNT
    w0 = we_cnt; e0 = err_cnt;
    send_byte(8'hA5, 1'b1);
    send_byte(8'h12, 1'b1);
    send_byte(8'h34, 1'b0);
    step(2);
    check("frerr_err", err_cnt - e0, 32'd1);
    check("frerr_busy", {31'd0, busy}, 32'd0);
    e0 = err_cnt;
    send_byte(8'h00, 1'b1);
    send_byte(8'h3C, 1'b1);
    send_byte(8'h55, 1'b0);
    step(5);
    check("garbage_no_err", err_cnt - e0, 32'd0);
    check("garbage_no_we", we_cnt - w0, 32'd0);

    // Timeout: 160 idle cycles after the address byte
    e0 = err_cnt;
    send_byte(8'hA5, 1'b1);
    e12 = cyc;
    send_byte(8'h12, 1'b1);
    step(300);
    check("timeout_err", err_cnt - e0, 32'd1);
    check("timeout_cycle", err_cyc, e12 + 80 + 160);
    check("timeout_busy", {31'd0, busy}, 32'd0);

    // Long gaps under the limit never time out: counter restarts on each byte
    w0 = we_cnt; e0 = err_cnt;
    send_frame(8'h40, 8'h0F, 8'hF0, 8'hBF, 150);
    check("gap_we", we_cnt - w0, 32'd1);
    check("gap_no_err", err_cnt - e0, 32'd0);

    // Glitch, then two back-to-back frames
    w0 = we_cnt; e0 = err_cnt;
    rx = 1'b0;
    step(2);
    rx = 1'b1;
    step(30);
    check("glitch_no_we", we_cnt - w0, 32'd0);
    check("glitch_no_err", err_cnt - e0, 32'd0);
    send_frame(8'h21, 8'h11, 8'h22, 8'h12, 0);
    send_frame(8'h22, 8'h33, 8'h44, 8'h55, 0);
    step(5);
    check("b2b_we_count", we_cnt - w0, 32'd2);
    check("b2b_addr", {24'd0, last_addr}, 32'h22);
    check("b2b_data", {16'd0, last_data}, 32'h4433);

    // Reset during the LO byte
    send_byte(8'hA5, 1'b1);
    send_byte(8'h12, 1'b1);
    rx = 1'b0;
    step(CPB);
    rx = 1'b1;
    step(2 * CPB);
    rst_n = 1'b0;
    #1;
    check("mid_rst_we", {31'd0, mem_we}, 32'd0);
    check("mid_rst_err", {31'd0, err}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_addr", {24'd0, mem_addr}, 32'd0);
    check("mid_rst_wdata", {16'd0, mem_wdata}, 32'd0);
    evq.delete();
    fbuf.delete();
    exp_busy = 1'b0; exp_addr = 8'h00; exp_data = 16'h0000;
    step(3);
    rst_n = 1'b1;
    step(5);
    w0 = we_cnt;
    send_frame(8'h3C, 8'h78, 8'h9A, 8'hDE, 0);
    step(5);
    check("post_rst_we", we_cnt - w0, 32'd1);
    check("post_rst_addr", {24'd0, last_addr}, 32'h3C);
    check("post_rst_data", {16'd0, last_data}, 32'h9A78);

    // Randomised frames with garbage, bad checksums, aborts and timeouts
    for (int f = 0; f < 40; f++) begin
      ng = $urandom_range(0, 2);
      for (int g = 0; g < ng; g++) begin
        b = 8'($urandom);
        if (b == SYNC) b = 8'h5A;
        send_byte(b, ($urandom_range(0, 3) != 0));
        step($urandom_range(0, 6));
      end
      fb[0] = SYNC;
      fb[1] = 8'($urandom);
      fb[2] = 8'($urandom);
      fb[3] = 8'($urandom);
      fb[4] = fb[1] ^ fb[2] ^ fb[3];
      if ($urandom_range(0, 3) == 0) fb[4] = fb[4] ^ 8'($urandom_range(1, 255));
      mode = $urandom_range(0, 9);
      p = $urandom_range(1, 4);
      for (int i = 0; i < 5; i++) begin
        if (mode == 0 && i == p) begin
          send_byte(fb[i], 1'b0);
          break;
        end
        send_byte(fb[i], 1'b1);
        if (mode == 1 && i == p - 1) step(250);
        else step($urandom_range(0, 20));
      end
      step($urandom_range(0, 10));
    end

    step(300);
    check("events_drained", evq.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
